// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serialises each one as an 11-bit keyboard-style frame on ps2_clk/ps2_data.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       host_inhibit,
  output logic                       ps2_clk,
  output logic                       ps2_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(HALF_PERIOD);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_GAP   = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

  state_t        state_r;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [10:0]   frame_r;
  logic [3:0]    bit_cnt_r;
  logic [DW-1:0] div_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic          retx_r;
  logic          ps2_clk_r;
  logic          ps2_data_r;

  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          gap_done_s;
  logic          pop_s;
  logic          push_s;
  logic [7:0]    head_s;

  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign fifo_full_s  = (count_r == CNT_FULL);
  assign gap_done_s   = (state_r == ST_GAP) && !host_inhibit && (gap_cnt_r == GAP_LAST);
  assign head_s       = mem_r[rd_ptr_r];

  // A new frame may start straight out of IDLE or at the end of a clean gap.
  assign pop_s = !fifo_empty_s &&
                 (((state_r == ST_IDLE) && !host_inhibit) || (gap_done_s && !retx_r));
  // A slot freed by a same-cycle pop can be refilled at once.
  assign in_ready = !fifo_full_s || pop_s;
  assign push_s   = in_valid && in_ready;

  assign fifo_count = count_r;
  assign ps2_clk    = ps2_clk_r;
  assign ps2_data   = ps2_data_r;
  assign busy       = (state_r != ST_IDLE) || !fifo_empty_s;

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CNT_ONE;
      end
    end
  end

  // Frame sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      frame_r    <= '0;
      bit_cnt_r  <= '0;
      div_cnt_r  <= '0;
      gap_cnt_r  <= '0;
      retx_r     <= 1'b0;
      ps2_clk_r  <= 1'b1;
      ps2_data_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ps2_clk_r <= 1'b1;
          if (pop_s) begin
            frame_r    <= build_frame(head_s);
            bit_cnt_r  <= '0;
            div_cnt_r  <= '0;
            ps2_data_r <= 1'b0;
            state_r    <= ST_HIGH;
          end else begin
            ps2_data_r <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (host_inhibit) begin
            retx_r     <= 1'b1;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            state_r    <= ST_ABORT;
          end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            ps2_clk_r <= 1'b0;
            state_r   <= ST_LOW;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_LOW: begin
          // The stop bit completing wins over a same-cycle inhibit.
          if ((div_cnt_r == DIV_LAST) && (bit_cnt_r == 4'd10)) begin
            gap_cnt_r  <= '0;
            retx_r     <= 1'b0;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            state_r    <= ST_GAP;
          end else if (host_inhibit) begin
            retx_r     <= 1'b1;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            state_r    <= ST_ABORT;
          end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r  <= '0;
            bit_cnt_r  <= bit_cnt_r + 4'd1;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= frame_r[bit_cnt_r + 4'd1];
            state_r    <= ST_HIGH;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end
        ST_ABORT: begin
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
          if (!host_inhibit) begin
            gap_cnt_r <= '0;
            state_r   <= ST_GAP;
          end else begin
            state_r <= ST_ABORT;
          end
        end
        ST_GAP: begin
          ps2_clk_r <= 1'b1;
          if (host_inhibit) begin
            gap_cnt_r  <= '0;
            ps2_data_r <= 1'b1;
          end else if (gap_cnt_r == GAP_LAST) begin
            bit_cnt_r <= '0;
            div_cnt_r <= '0;
            if (retx_r) begin
              retx_r     <= 1'b0;
              ps2_data_r <= frame_r[0];
              state_r    <= ST_HIGH;
            end else if (pop_s) begin
              frame_r    <= build_frame(head_s);
              ps2_data_r <= 1'b0;
              state_r    <= ST_HIGH;
            end else begin
              ps2_data_r <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            gap_cnt_r  <= gap_cnt_r + GAP_ONE;
            ps2_data_r <= 1'b1;
          end
        end
        default: begin
          retx_r     <= 1'b0;
          ps2_clk_r  <= 1'b1;
          ps2_data_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a PS/2 receiver model decodes the bus and each
// scenario task compares the decoded frames and timing with its own model.
module tb_ps2_device_tx;

  localparam int HP    = 4;
  localparam int GAP   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       host_inhibit = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .host_inhibit(host_inhibit), .ps2_clk(ps2_clk),
    .ps2_data(ps2_data), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: samples data on each ps2_clk falling edge.
  logic [10:0] mon_bits = 11'd0;
  int          mon_nb = 0;
  int          mon_last_fall = 0;
  int          mon_start = 0;
  int          mon_falls = 0;
  int          mon_aborts = 0;
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  logic [10:0] frames_q[$];
  int          fstart_q[$];
  int          fend_q[$];

  always @(negedge clk) begin
    if (!resetn) begin
      if (mon_nb > 0) mon_aborts++;
      mon_nb = 0;
    end else if (prev_clk && !ps2_clk) begin
      if (mon_nb < 11) mon_bits[mon_nb] = ps2_data;
      mon_nb++;
      mon_falls++;
      mon_last_fall = cyc;
    end else if (!prev_clk && ps2_clk && mon_nb == 11) begin
      frames_q.push_back(mon_bits);
      fstart_q.push_back(mon_start);
      fend_q.push_back(cyc);
      mon_nb = 0;
    end else if (mon_nb == 0 && ps2_clk && prev_data && !ps2_data) begin
      mon_start = cyc;
    end else if (mon_nb > 0 && ps2_clk && (cyc - mon_last_fall) > 2*HP + 1) begin
      mon_nb = 0;
      mon_aborts++;
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    host_inhibit = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    step();
    frames_q.delete();
    fstart_q.delete();
    fend_q.delete();
    mon_falls = 0;
    mon_aborts = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames_q.size() < n; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b1;
    in_data = 8'($urandom);
    repeat (2) step();
    total++; if (ps2_clk !== 1'b1) begin bad++; $display("FAIL reset_clk got=%b want=1", ps2_clk); end
    total++; if (ps2_data !== 1'b1) begin bad++; $display("FAIL reset_data got=%b want=1", ps2_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    resetn = 1'b1;
    in_valid = 1'b0;
    step();
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_push_ignored got=%0d want=0", fifo_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single_frame();
    int e;
    do_reset();
    push_byte(8'h1C);
    wait_frames(1, 300);
    total++; if (frames_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", frames_q.size()); end
    if (frames_q.size() >= 1) begin
      total++; if (frames_q[0] !== 11'b100_0011_1000) begin bad++; $display("FAIL single_bits got=%b want=10000111000", frames_q[0]); end
      total++; if (fend_q[0] - fstart_q[0] !== 22*HP) begin bad++; $display("FAIL single_len got=%0d want=%0d", fend_q[0] - fstart_q[0], 22*HP); end
      e = fend_q[0];
      while (cyc < e + GAP) begin
        total++;
        if (!(ps2_clk === 1'b1 && ps2_data === 1'b1 && busy === 1'b1)) begin
          bad++; $display("FAIL single_gap cyc=%0d got clk=%b data=%b busy=%b want 1,1,1", cyc - e, ps2_clk, ps2_data, busy);
        end
        step();
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h00;
    step();
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_first got=%0d want=1", fifo_count); end
    in_data = 8'hF0;
    step();
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_popped got=%0d want=1", fifo_count); end
    total++; if (ps2_data !== 1'b0 || ps2_clk !== 1'b1) begin bad++; $display("FAIL b2b_start got clk=%b data=%b want 1,0", ps2_clk, ps2_data); end
    wait_frames(1, 300);
    step();
    for (int i = 0; i < 40 && !(ps2_clk === 1'b1 && ps2_data === 1'b0); i++) step();
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_count_second got=%0d want=0", fifo_count); end
    wait_frames(2, 300);
    total++; if (frames_q.size() !== 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", frames_q.size()); end
    if (frames_q.size() >= 2) begin
      total++; if (frames_q[0] !== model_frame(8'h00) || frames_q[0][9] !== 1'b1) begin bad++; $display("FAIL b2b_frame0 got=%b want=%b", frames_q[0], model_frame(8'h00)); end
      total++; if (frames_q[1] !== model_frame(8'hF0) || frames_q[1][9] !== 1'b1) begin bad++; $display("FAIL b2b_frame1 got=%b want=%b", frames_q[1], model_frame(8'hF0)); end
      total++; if (fstart_q[1] - fend_q[0] !== GAP) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", fstart_q[1] - fend_q[0], GAP); end
    end
  endtask

  task automatic test_inhibit_fill();
    logic [7:0] b [6];
    logic [7:0] base;
    logic       exp_ready;
    int         k = 0;
    int         mcount = 0;
    base = 8'($urandom);
    for (int i = 0; i < 6; i++) b[i] = base ^ 8'(i * 43);
    do_reset();
    host_inhibit = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data = b[k];
      exp_ready = (mcount < DEPTH);
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL fill_ready cyc=%0d got=%b want=%b", c, in_ready, exp_ready); end
      step();
      if (exp_ready) begin k++; mcount++; end
    end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", fifo_count); end
    total++; if (mon_falls !== 0 || ps2_clk !== 1'b1) begin bad++; $display("FAIL fill_no_clock got falls=%0d want=0", mon_falls); end
    host_inhibit = 1'b0;
    #1;
    for (int i = 0; i < 600 && k < 6; i++) begin
      logic acc;
      acc = in_ready;
      step();
      if (acc) begin
        k++;
        if (k < 6) in_data = b[k];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    wait_frames(6, 1000);
    total++; if (frames_q.size() !== 6) begin bad++; $display("FAIL fill_frames got=%0d want=6", frames_q.size()); end
    for (int i = 0; i < 6 && i < frames_q.size(); i++) begin
      total++; if (frames_q[i] !== model_frame(b[i])) begin bad++; $display("FAIL fill_order idx=%0d got=%b want=%b", i, frames_q[i], model_frame(b[i])); end
    end
  endtask

  task automatic test_abort_retry();
    logic [7:0] b2;
    int r;
    b2 = 8'($urandom);
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h5A;
    step();
    in_data = b2;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !(mon_nb == 5 && ps2_clk === 1'b1); i++) step();
    repeat ($urandom_range(0, 2)) step();
    host_inhibit = 1'b1;
    step();
    total++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin bad++; $display("FAIL abort_idle got clk=%b data=%b want 1,1", ps2_clk, ps2_data); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL abort_count got=%0d want=1", fifo_count); end
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin bad++; $display("FAIL abort_hold i=%0d got clk=%b data=%b want 1,1", i, ps2_clk, ps2_data); end
    end
    host_inhibit = 1'b0;
    r = cyc;
    wait_frames(1, 300);
    total++; if (frames_q.size() !== 1) begin bad++; $display("FAIL abort_frames got=%0d want=1", frames_q.size()); end
    total++; if (mon_aborts !== 1) begin bad++; $display("FAIL abort_partial got=%0d want=1", mon_aborts); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL abort_count_after got=%0d want=1", fifo_count); end
    if (frames_q.size() >= 1) begin
      total++; if (frames_q[0] !== model_frame(8'h5A)) begin bad++; $display("FAIL abort_resend got=%b want=%b", frames_q[0], model_frame(8'h5A)); end
      total++; if (fstart_q[0] - r !== GAP + 1) begin bad++; $display("FAIL abort_restart_delay got=%0d want=%0d", fstart_q[0] - r, GAP + 1); end
      total++; if (fend_q[0] - fstart_q[0] !== 22*HP) begin bad++; $display("FAIL abort_len got=%0d want=%0d", fend_q[0] - fstart_q[0], 22*HP); end
    end
    wait_frames(2, 300);
    total++; if (frames_q.size() !== 2 || frames_q[frames_q.size()-1] !== model_frame(b2)) begin bad++; $display("FAIL abort_next got=%0d frames want=2 ending %b", frames_q.size(), model_frame(b2)); end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    int lows = 0;
    do_reset();
    push_byte(8'($urandom));
    for (int i = 0; i < 300 && mon_nb < 3 + int'($urandom_range(0, 4)); i++) step();
    resetn = 1'b0;
    step();
    total++; if (ps2_clk !== 1'b1 || ps2_data !== 1'b1) begin bad++; $display("FAIL midreset_bus got clk=%b data=%b want 1,1", ps2_clk, ps2_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", fifo_count); end
    resetn = 1'b1;
    f0 = mon_falls;
    repeat (40) begin
      step();
      if (ps2_clk !== 1'b1) lows++;
    end
    total++; if (lows !== 0 || mon_falls !== f0) begin bad++; $display("FAIL midreset_edges got lows=%0d falls=%0d want 0,%0d", lows, mon_falls, f0); end
    total++; if (frames_q.size() !== 0) begin bad++; $display("FAIL midreset_decoded got=%0d want=0", frames_q.size()); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b [5];
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    do_reset();
    host_inhibit = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(b[i]);
    in_valid = 1'b1;
    in_data = b[4];
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fullpop_full_ready got=%b want=0", in_ready); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fullpop_full_count got=%0d want=4", fifo_count); end
    host_inhibit = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d want=4", fifo_count); end
    total++; if (ps2_data !== 1'b0) begin bad++; $display("FAIL fullpop_start got=%b want=0", ps2_data); end
    wait_frames(5, 1000);
    total++; if (frames_q.size() !== 5) begin bad++; $display("FAIL fullpop_frames got=%0d want=5", frames_q.size()); end
    for (int i = 0; i < 5 && i < frames_q.size(); i++) begin
      total++; if (frames_q[i] !== model_frame(b[i])) begin bad++; $display("FAIL fullpop_order idx=%0d got=%b want=%b", i, frames_q[i], model_frame(b[i])); end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    int n = 8;
    do_reset();
    for (int j = 0; j < n; j++) begin
      logic acc = 1'b0;
      in_valid = 1'b1;
      in_data = 8'($urandom);
      exp_q.push_back(in_data);
      for (int i = 0; i < 400 && !acc; i++) begin
        acc = in_ready;
        step();
      end
      in_valid = 1'b0;
      repeat ($urandom_range(0, 120)) step();
    end
    wait_frames(n, 2000);
    total++; if (frames_q.size() !== n) begin bad++; $display("FAIL rand_frames got=%0d want=%0d", frames_q.size(), n); end
    for (int i = 0; i < n && i < frames_q.size(); i++) begin
      total++; if (frames_q[i] !== model_frame(exp_q[i])) begin bad++; $display("FAIL rand_frame idx=%0d got=%b want=%b", i, frames_q[i], model_frame(exp_q[i])); end
      total++; if (fend_q[i] - fstart_q[i] !== 22*HP) begin bad++; $display("FAIL rand_len idx=%0d got=%0d want=%0d", i, fend_q[i] - fstart_q[i], 22*HP); end
      if (i > 0) begin
        total++; if (fstart_q[i] - fend_q[i-1] < GAP) begin bad++; $display("FAIL rand_gap idx=%0d got=%0d want>=%0d", i, fstart_q[i] - fend_q[i-1], GAP); end
      end
    end
    repeat (GAP + 2) step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy_end got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_inhibit_fill();
    test_abort_retry();
    test_reset_mid_frame();
    test_full_pop();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
